// File: rtl/conv3x3_mac.sv
// conv3x3_mac: pipelined 3x3 signed fixed-point MAC with bias, rounding, saturation and ReLU
module conv3x3_mac #(
  parameter int data_width = 16,
  parameter int frac_bits  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  weight_load,
  input  logic [data_width-1:0] weight_in,
  output logic                  weights_ready,
  input  logic                  window_valid,
  input  logic [data_width-1:0] win_0,
  input  logic [data_width-1:0] win_1,
  input  logic [data_width-1:0] win_2,
  input  logic [data_width-1:0] win_3,
  input  logic [data_width-1:0] win_4,
  input  logic [data_width-1:0] win_5,
  input  logic [data_width-1:0] win_6,
  input  logic [data_width-1:0] win_7,
  input  logic [data_width-1:0] win_8,
  input  logic                  relu_en,
  output logic [data_width-1:0] data_out,
  output logic                  output_valid,
  output logic                  drop_err
);
  localparam int DW = data_width;
  localparam int PW = 2 * DW;
  localparam int SW = PW + 2;
  localparam int AW = PW + 4;
  localparam logic signed [AW-1:0] half = {{(AW-1){1'b0}}, 1'b1} << (frac_bits - 1);
  localparam logic signed [DW-1:0] hi = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] lo = {1'b1, {(DW-1){1'b0}}};

  logic signed [DW-1:0] coef [10];
  logic        [3:0]    slot;
  logic signed [DW-1:0] win  [9];
  logic                 accept;
  logic signed [PW-1:0] p    [9];
  logic signed [SW-1:0] s    [3];
  logic signed [DW-1:0] b1, b2;
  logic signed [AW-1:0] acc, rnd;
  logic                 v1, v2, v3, v4, r1, r2, r3, r4;
  logic signed [DW-1:0] sat, res;

  assign win    = '{win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8};
  assign accept = window_valid & weights_ready & ~weight_load;

  // serial coefficient loader; slot 9 is the bias and completes the set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot          <= '0;
      weights_ready <= 1'b0;
      for (int i = 0; i < 10; i++) coef[i] <= '0;
    end else if (weight_load) begin
      coef[slot]    <= weight_in;
      slot          <= slot == 4'd9 ? 4'd0 : slot + 4'd1;
      weights_ready <= slot == 4'd9;
    end
  end

  // sticky flag for windows that arrive while coefficients are unavailable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_err <= 1'b0;
    else if (window_valid & ~accept) drop_err <= 1'b1;
  end

  // multiply, tree-add, bias and round stages; valids shift unconditionally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) p[i] <= '0;
      for (int i = 0; i < 3; i++) s[i] <= '0;
      {b1, b2, acc, rnd} <= '0;
      {v1, v2, v3, v4, r1, r2, r3, r4} <= '0;
    end else begin
      for (int i = 0; i < 9; i++) p[i] <= PW'(win[i]) * PW'(coef[i]);
      b1 <= coef[9];
      r1 <= relu_en;
      v1 <= accept;
      for (int i = 0; i < 3; i++) s[i] <= SW'(p[3*i]) + SW'(p[3*i+1]) + SW'(p[3*i+2]);
      b2 <= b1;
      r2 <= r1;
      v2 <= v1;
      acc <= AW'(s[0]) + AW'(s[1]) + AW'(s[2]) + (AW'(b2) <<< frac_bits);
      r3  <= r2;
      v3  <= v2;
      rnd <= (acc + half) >>> frac_bits;
      r4  <= r3;
      v4  <= v3;
    end
  end

  // saturate to the output range, then optional ReLU
  always_comb begin
    sat = rnd > AW'(hi) ? hi : rnd < AW'(lo) ? lo : rnd[DW-1:0];
    res = r4 && sat[DW-1] ? '0 : sat;
  end

  // output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out     <= '0;
      output_valid <= 1'b0;
    end else begin
      data_out     <= res;
      output_valid <= v4;
    end
  end
endmodule

// File: tb/tb_conv3x3_mac.sv
// tb_conv3x3_mac: directed scoreboard bench for conv3x3_mac
module tb_conv3x3_mac;
  typedef struct {
    logic [15:0] v;
    int          due;
  } exp_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        weight_load = 0;
  logic [15:0] weight_in = 0;
  logic        window_valid = 0;
  logic        relu_en = 0;
  logic [15:0] t [9];
  logic [15:0] data_out;
  logic        output_valid, weights_ready, drop_err;
  exp_t        q [$];
  exp_t        e;
  int          vectors = 0;
  int          errs = 0;
  int          cyc = 0;

  conv3x3_mac #(.data_width(16), .frac_bits(8)) dut (
    .clk(clk), .rst(rst), .weight_load(weight_load), .weight_in(weight_in),
    .weights_ready(weights_ready), .window_valid(window_valid),
    .win_0(t[0]), .win_1(t[1]), .win_2(t[2]), .win_3(t[3]), .win_4(t[4]),
    .win_5(t[5]), .win_6(t[6]), .win_7(t[7]), .win_8(t[8]),
    .relu_en(relu_en), .data_out(data_out), .output_valid(output_valid),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && output_valid) begin
      vectors++;
      if (q.size() == 0) begin
        assert (output_valid === 1'b0) else begin
          errs++;
          $error("FAIL spurious_valid observed=%b expected=0", output_valid);
        end
      end else begin
        e = q.pop_front();
        assert (data_out === e.v && cyc === e.due) else begin
          errs++;
          $error("FAIL out observed=%h@%0d expected=%h@%0d", data_out, cyc, e.v, e.due);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input int from, input int to, input logic [15:0] w0, input logic [15:0] wr,
                      input logic [15:0] b);
    for (int s = from; s <= to; s++) begin
      @(negedge clk);
      window_valid = 0;
      weight_load  = 1;
      weight_in    = s == 0 ? w0 : s == 9 ? b : wr;
    end
  endtask

  task automatic win(input logic [15:0] t0, input logic [15:0] tr, input logic re, input bit push,
                     input logic [15:0] ev);
    @(negedge clk);
    weight_load  = 0;
    window_valid = 1;
    relu_en      = re;
    t[0]         = t0;
    for (int k = 1; k < 9; k++) t[k] = tr;
    if (push) q.push_back('{ev, cyc + 5});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      window_valid = 0;
      weight_load  = 0;
    end
  endtask

  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    chk("drain_pending", 16'(q.size()), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 9; k++) t[k] = 0;
    #3 rst = 0;
    idle(3);
    chk("rst_data_out", data_out, 16'h0);
    chk("rst_output_valid", 16'(output_valid), 16'h0);
    chk("rst_weights_ready", 16'(weights_ready), 16'h0);
    chk("rst_drop_err", 16'(drop_err), 16'h0);
    @(negedge clk);
    rst = 1;
    load(0, 9, 16'h0100, 16'h0100, 16'h0000);
    win(16'h0100, 16'h0100, 0, 1, 16'h0900);
    drain();
    chk("ready_after_load", 16'(weights_ready), 16'h1);
    load(0, 9, 16'h0080, 16'h0000, 16'h0000);
    win(16'h0001, 16'h0000, 0, 1, 16'h0001);
    win(16'hFFFF, 16'h0000, 0, 1, 16'h0000);
    load(0, 9, 16'h0040, 16'h0000, 16'h0000);
    win(16'h0003, 16'h0000, 0, 1, 16'h0001);
    drain();
    load(0, 9, 16'h7FFF, 16'h7FFF, 16'h0000);
    win(16'h7FFF, 16'h7FFF, 0, 1, 16'h7FFF);
    win(16'h8000, 16'h8000, 0, 1, 16'h8000);
    drain();
    load(0, 9, 16'hFF00, 16'h0000, 16'h0000);
    win(16'h0200, 16'h0000, 0, 1, 16'hFE00);
    win(16'h0200, 16'h0000, 1, 1, 16'h0000);
    drain();
    load(0, 9, 16'h0100, 16'h0100, 16'h0100);
    for (int k = 1; k <= 6; k++) win(16'(k * 16), 16'(k * 16), 0, 1, 16'(16'h0100 + k * 16'h0090));
    drain();
    chk("no_drop_yet", 16'(drop_err), 16'h0);
    load(0, 2, 16'h0100, 16'h0100, 16'h0100);
    win(16'h0010, 16'h0010, 0, 0, 16'h0000);
    idle(1);
    chk("partial_not_ready", 16'(weights_ready), 16'h0);
    chk("drop_err_set", 16'(drop_err), 16'h1);
    idle(6);
    load(3, 9, 16'h0100, 16'h0100, 16'h0100);
    win(16'h0010, 16'h0010, 0, 0, 16'h0000);
    win(16'h0020, 16'h0020, 0, 0, 16'h0000);
    win(16'h0030, 16'h0030, 0, 0, 16'h0000);
    @(posedge clk);
    #1 rst = 0;
    window_valid = 0;
    #1;
    chk("mid_rst_data_out", data_out, 16'h0);
    chk("mid_rst_output_valid", 16'(output_valid), 16'h0);
    chk("mid_rst_weights_ready", 16'(weights_ready), 16'h0);
    chk("mid_rst_drop_err", 16'(drop_err), 16'h0);
    idle(2);
    @(negedge clk);
    rst = 1;
    idle(10);
    chk("final_queue", 16'(q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
